// File: rtl/alu_pkg.sv
// alu_pkg: shared op and FSM state encodings for the serial logic unit
package alu_pkg;
  typedef enum logic [1:0] {OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2, OP_NAND = 2'd3} op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/logic_bit_op.sv
// logic_bit_op: single-bit AND/OR/XOR/NAND selected by op
// ports: a, b operand bits; op operation; r result bit
module logic_bit_op
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_t  op,
  output logic r
);
  always_comb r = op == OP_AND ? a & b :
                  op == OP_OR  ? a | b :
                  op == OP_XOR ? a ^ b : ~(a & b);
endmodule

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial bitwise logic unit with valid/ready handshakes
// ports: clk, rst (sync, active-high); in_valid/in_ready with op, x, y operands;
//        out_valid/out_ready with result and registered zero flag
module serial_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, nxt;
  logic [WIDTH-1:0] xr, yr;
  op_t opr;
  logic [CW-1:0] cnt;
  logic bit_r;
  logic [WIDTH:0] cat;
  logic [WIDTH-1:0] shifted;
  logic accept, last;
  logic_bit_op u_bit (.a(xr[cnt]), .b(yr[cnt]), .op(opr), .r(bit_r));
  // new bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts
  assign cat      = {bit_r, result};
  assign shifted  = cat[WIDTH:1];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept   = in_valid && in_ready;
  assign last     = cnt == LAST;
  always_comb begin
    nxt = state;
    nxt = state == IDLE  && in_valid  ? SHIFT :
          state == SHIFT && last      ? DONE  :
          state == DONE  && out_ready ? IDLE  : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      xr     <= '0;
      yr     <= '0;
      opr    <= OP_AND;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else if (accept) begin
      xr     <= x;
      yr     <= y;
      opr    <= op_t'(op);
      cnt    <= '0;
      result <= '0;
    end else if (state == SHIFT) begin
      result <= shifted;
      cnt    <= last ? '0 : cnt + 1'b1;
      if (last) zero <= shifted == '0;
    end
  end
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: table, hand-sequence and random checks of serial_logic_unit
module tb_serial_logic_unit;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, zero;
  logic [1:0] op;
  logic [7:0] x, y, result;
  int         total = 0, passed = 0;

  serial_logic_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] x, y, r;
    logic       z;
  } vec_t;
  vec_t vt[8];

  function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    return o == 2'd0 ? a & b : o == 2'd1 ? a | b : o == 2'd2 ? a ^ b : ~(a & b);
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %0h want %0h", n, got, exp);
  endtask

  // called at a negedge in IDLE; returns at the sample after the accept edge with junk on the inputs
  task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = o; x = a; y = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 2'($urandom); x = 8'($urandom); y = 8'($urandom);
  endtask

  // lat counts cycles with the accept cycle as 0, so the first sample after the accept edge is 1
  task automatic collect(input int stall, output logic [7:0] r, output logic z, output int lat);
    out_ready = stall == 0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    r = result; z = zero;
    for (int i = 0; i < stall; i++) begin
      chk("in_ready_busy", in_ready, 0);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, r);
      chk("hold_zero", zero, z);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("ov_drop", out_valid, 0);
    chk("idle_after", in_ready, 1);
    chk("result_kept", result, r);
  endtask

  logic [7:0] r, a, b;
  logic       z;
  logic [1:0] o;
  int         lat, seen;

  initial begin
    vt[0] = '{2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vt[1] = '{2'd1, 8'hA5, 8'h5A, 8'hFF, 1'b0};
    vt[2] = '{2'd3, 8'h0F, 8'h33, 8'hFC, 1'b0};
    vt[3] = '{2'd2, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vt[4] = '{2'd0, 8'h00, 8'hFF, 8'h00, 1'b1};
    vt[5] = '{2'd3, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vt[6] = '{2'd2, 8'h5A, 8'h0F, 8'h55, 1'b0};
    vt[7] = '{2'd1, 8'h00, 8'h01, 8'h01, 1'b0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'd0; x = 8'h00; y = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(vt[i].op, vt[i].x, vt[i].y);
      collect(i % 2, r, z, lat);
      chk($sformatf("vec%0d_lat", i), lat, 9);
      chk($sformatf("vec%0d_result", i), r, vt[i].r);
      chk($sformatf("vec%0d_zero", i), z, vt[i].z);
    end

    // stalled consumer while a new operand set is already waiting
    send(2'd0, 8'hF0, 8'h3C);
    in_valid = 1'b1; op = 2'd1; x = 8'h0C; y = 8'h30;
    collect(5, r, z, lat);
    chk("stall_lat", lat, 9);
    chk("stall_result", r, 8'h30);
    @(posedge clk);
    @(negedge clk);
    chk("queued_accepted", in_ready, 0);
    in_valid = 1'b0;
    collect(0, r, z, lat);
    chk("queued_lat", lat, 9);
    chk("queued_result", r, 8'h3C);
    chk("queued_zero", z, 0);

    // reset in the fourth SHIFT cycle abandons the operation
    send(2'd2, 8'hAA, 8'h55);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", in_ready, 1);
    chk("abort_result", result, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_valid", seen, 0);
    send(2'd0, 8'hFF, 8'h81);
    collect(0, r, z, lat);
    chk("post_abort_result", r, 8'h81);
    chk("post_abort_lat", lat, 9);

    // reset beats a simultaneous accept
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_prio", in_ready, 1);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(o, a, b);
      collect(int'($urandom_range(0, 3)), r, z, lat);
      chk($sformatf("rnd%0d_result", i), r, model(o, a, b));
      chk($sformatf("rnd%0d_zero", i), z, model(o, a, b) == 8'h00);
      chk($sformatf("rnd%0d_lat", i), lat, 9);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  unit can accept an operand set.
REQ-006 SHALL have port: op  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=NAND.
REQ-007 SHALL have port: x  input  WIDTH  operand X.
REQ-008 SHALL have port: y  input  WIDTH  operand Y.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  WIDTH  computed result.
REQ-012 SHALL have port: zero  output  1  result equals 0.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-015 Accept = in_valid & in_ready at a clock edge; on accept SHALL latch x, y, op, clear the result shift register and bit counter, and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL compute one result bit from operand bit i (LSB first) per latched op and shift it in at the MSB end of the result register.
REQ-017 After exactly WIDTH SHIFT cycles (counter WIDTH-1 -> 0 wrap), SHALL enter DONE; result bit i SHALL equal op(x[i], y[i]) for all i.
REQ-018 Latency: out_valid SHALL rise WIDTH+1 cycles after the accept edge (9 cycles for WIDTH=8).
REQ-019 In DONE, out_valid SHALL be 1 and result/zero SHALL stay stable until out_valid & out_ready.
REQ-020 On out_valid & out_ready, SHALL return to IDLE; out_valid deasserts next cycle; result holds last value.
REQ-021 in_valid, x, y, op changes during SHIFT/DONE SHALL be ignored.
REQ-022 Bit counter width SHALL be $clog2(WIDTH), minimum 1; no other width truncation permitted.
REQ-023 zero SHALL be registered and valid whenever out_valid is 1.
REQ-024 Back-to-back: in_valid held high SHALL be accepted in the cycle after the DONE handshake (one IDLE cycle between results).

Reset
REQ-025 While rst is 1 at an edge: state=IDLE, result=0, zero=0, out_valid=0, counter=0, latched operands=0; in_ready=1 after the reset edge.
REQ-026 rst asserted during SHIFT or DONE SHALL abandon the operation; no out_valid for it.
REQ-027 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-028 Op encodings (OP_AND..OP_NAND) and state encodings SHALL live in shared package alu_pkg.
REQ-029 Per-bit combinational function SHALL be sub-module logic_bit_op (inputs a, b, op; output r); FSM, counter and shift registers stay in serial_logic_unit.

Verification
REQ-030 op=AND, x=0xF0, y=0x3C, out_ready=1 -> out_valid 9 cycles after accept, result=0x30, zero=0.
REQ-031 op=OR, x=0xA5, y=0x5A -> result=0xFF, zero=0; op=NAND, x=0x0F, y=0x33 -> result=0xFC.
REQ-032 op=XOR, x=0xFF, y=0xFF -> result=0x00, zero=1.
REQ-033 out_ready=0 for 5 cycles after out_valid -> out_valid, result stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle, queued set accepted cycle after.
REQ-034 rst pulse at SHIFT cycle 4 -> IDLE, out_valid never asserts for that op, next op (AND 0xFF,0x81) -> 0x81.
